// File: rtl/ber_pkg.sv
// ber_pkg: shared parameter defaults and FSM state encodings for the BER checker
package ber_pkg;
   localparam int NB_CNT_DEF  = 64;
   localparam int NB_DLY_DEF  = 9;
   localparam int WINDOW_DEF  = 511;
   localparam int ERR_THR_DEF = 0;
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_LOCK   = 2'd2;
endpackage

// File: rtl/ref_delay_line.sv
// ref_delay_line: reference-bit shift line with a selectable tap
// Ports: clock, i_reset_n (async, active low), i_valid (shift strobe),
//        i_bit (new reference bit), i_sel (tap index), o_bit (selected tap).
// Tap 0 is the live input bit; tap k is the bit shifted in k strobes earlier.
module ref_delay_line
   import ber_pkg::*;
#(
   parameter int NB_DLY = NB_DLY_DEF
) (
   input  logic              clock,
   input  logic              i_reset_n,
   input  logic              i_valid,
   input  logic              i_bit,
   input  logic [NB_DLY-1:0] i_sel,
   output logic              o_bit
);
   localparam int DEPTH = 2 ** NB_DLY;
   logic [DEPTH-1:1] r_line;
   logic [DEPTH-1:0] w_taps;
   assign w_taps = {r_line, i_bit};
   assign o_bit  = w_taps[i_sel];
   always_ff @(posedge clock or negedge i_reset_n)
      if (!i_reset_n) r_line <= '0;
      else if (i_valid) r_line <= w_taps[DEPTH-2:0];
endmodule

// File: rtl/ber_checker.sv
// ber_checker: PRBS bit-error-rate checker with automatic alignment search
// Ports: clock, i_reset_n (async, active low), i_enable, i_resync (pulse),
//        i_valid (symbol strobe), i_ref_bit, i_rx_bit,
//        o_bits / o_errors (saturating counts while locked), o_locked, o_delay.
module ber_checker
   import ber_pkg::*;
#(
   parameter int NB_CNT  = NB_CNT_DEF,
   parameter int NB_DLY  = NB_DLY_DEF,
   parameter int WINDOW  = WINDOW_DEF,
   parameter int ERR_THR = ERR_THR_DEF
) (
   input  logic              clock,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic              i_resync,
   input  logic              i_valid,
   input  logic              i_ref_bit,
   input  logic              i_rx_bit,
   output logic [NB_CNT-1:0] o_bits,
   output logic [NB_CNT-1:0] o_errors,
   output logic              o_locked,
   output logic [NB_DLY-1:0] o_delay
);
   localparam int NB_WIN = $clog2(WINDOW + 1);
   localparam logic [31:0] THR = 32'(ERR_THR);

   logic [1:0]        r_state;
   logic [NB_DLY-1:0] r_delay;
   logic [NB_WIN-1:0] r_win_cnt;
   logic [NB_WIN-1:0] r_win_err;
   logic [NB_CNT-1:0] r_bits;
   logic [NB_CNT-1:0] r_errors;
   logic              w_ref;
   logic              w_mis;
   logic              w_win_end;
   logic [NB_WIN-1:0] w_win_tot;
   logic [NB_CNT-1:0] w_bits_nxt;
   logic [NB_CNT-1:0] w_errors_nxt;

   ref_delay_line #(.NB_DLY(NB_DLY)) u_dly (
      .clock     (clock),
      .i_reset_n (i_reset_n),
      .i_valid   (i_valid),
      .i_bit     (i_ref_bit),
      .i_sel     (r_delay),
      .o_bit     (w_ref)
   );

   assign w_mis        = i_rx_bit ^ w_ref;
   // window total includes the current bit so the last bit of a window counts
   assign w_win_tot    = &r_win_err ? r_win_err : r_win_err + NB_WIN'(w_mis);
   assign w_win_end    = r_win_cnt == NB_WIN'(WINDOW - 1);
   assign w_bits_nxt   = &r_bits ? r_bits : r_bits + NB_CNT'(1'b1);
   assign w_errors_nxt = &r_errors ? r_errors : r_errors + NB_CNT'(w_mis);

   assign o_bits   = r_bits;
   assign o_errors = r_errors;
   assign o_locked = r_state == ST_LOCK;
   assign o_delay  = r_delay;

   // enable low wins over resync, which wins over a sample; a sample on the
   // same edge as either event is dropped
   always_ff @(posedge clock or negedge i_reset_n)
      if (!i_reset_n) begin
         r_state   <= ST_IDLE;
         r_delay   <= '0;
         r_win_cnt <= '0;
         r_win_err <= '0;
         r_bits    <= '0;
         r_errors  <= '0;
      end else if (!i_enable) begin
         r_state <= ST_IDLE;
      end else if (r_state == ST_IDLE || i_resync) begin
         r_state   <= ST_SEARCH;
         r_delay   <= '0;
         r_win_cnt <= '0;
         r_win_err <= '0;
         r_bits    <= '0;
         r_errors  <= '0;
      end else if (i_valid) begin
         if (r_state == ST_SEARCH) begin
            if (w_win_end) begin
               if (32'(w_win_tot) <= THR) r_state <= ST_LOCK;
               else r_delay <= r_delay + NB_DLY'(1'b1);
               r_win_cnt <= '0;
               r_win_err <= '0;
            end else begin
               r_win_cnt <= r_win_cnt + NB_WIN'(1'b1);
               r_win_err <= w_win_tot;
            end
         end else if (r_state == ST_LOCK) begin
            r_bits   <= w_bits_nxt;
            r_errors <= w_errors_nxt;
         end
      end
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: randomized PRBS9 stimulus checked against a behavioural BER model
module tb_ber_checker;
   localparam int W    = 16;
   localparam int DMAX = 512;

   logic clock = 0, rst_n = 0, en = 0, rs = 0, valid = 0, ref_b = 0, rx = 0, en2 = 0;
   logic inv2 = 0, rx2;
   logic [63:0] bits, errs;
   logic        locked, locked2;
   logic [8:0]  dly, dly2;
   logic [3:0]  bits2, errs2;

   assign rx2 = rx ^ inv2;
   always #5 clock = ~clock;

   ber_checker #(.NB_CNT(64), .NB_DLY(9), .WINDOW(W), .ERR_THR(0)) dut (
      .clock(clock), .i_reset_n(rst_n), .i_enable(en), .i_resync(rs), .i_valid(valid),
      .i_ref_bit(ref_b), .i_rx_bit(rx), .o_bits(bits), .o_errors(errs),
      .o_locked(locked), .o_delay(dly));

   ber_checker #(.NB_CNT(4), .NB_DLY(9), .WINDOW(W), .ERR_THR(0)) dut2 (
      .clock(clock), .i_reset_n(rst_n), .i_enable(en2), .i_resync(1'b0), .i_valid(valid),
      .i_ref_bit(ref_b), .i_rx_bit(rx2), .o_bits(bits2), .o_errors(errs2),
      .o_locked(locked2), .o_delay(dly2));

   int n_chk = 0, n_pass = 0;
   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // stimulus: continuous PRBS9 history; rx is ref delayed by dly_rx strobes
   // counted from segment start seg (zeros before it), or constant 0
   bit       g_ref[$];
   logic [8:0] lfsr;
   int       dly_rx = 5, seg = 0;
   bit       rx_zero = 0, inv = 0;

   // model of dut: spec-level state (0 idle, 1 search, 2 lock)
   int     m_st, m_delay, m_win, m_werr, m_base;
   longint m_bits, m_errs;

   function automatic bit refd(int k);
      int n = g_ref.size() - 1;
      return (n - k >= m_base) ? g_ref[n - k] : 1'b0;
   endfunction

   task automatic m_reset();
      m_st = 0; m_delay = 0; m_win = 0; m_werr = 0; m_bits = 0; m_errs = 0;
      m_base = g_ref.size();
   endtask

   task automatic model_edge();
      bit mis;
      if (!rst_n) return;
      if (!en) m_st = 0;
      else if (m_st == 0 || rs) begin
         m_st = 1; m_delay = 0; m_win = 0; m_werr = 0; m_bits = 0; m_errs = 0;
      end else if (valid) begin
         mis = rx ^ refd(m_delay);
         if (m_st == 1) begin
            m_win++;
            m_werr += int'(mis);
            if (m_win == W) begin
               if (m_werr == 0) m_st = 2;
               else m_delay = (m_delay + 1) % DMAX;
               m_win = 0;
               m_werr = 0;
            end
         end else begin
            m_bits++;
            m_errs += longint'(mis);
         end
      end
   endtask

   task automatic tick(bit v);
      int n;
      valid = v;
      if (v) begin
         g_ref.push_back(lfsr[8]);
         lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
         n = g_ref.size() - 1;
         ref_b = g_ref[n];
         rx = rx_zero ? 1'b0 : ((n - dly_rx >= seg) ? g_ref[n - dly_rx] : 1'b0);
         rx = rx ^ inv;
      end else begin
         ref_b = 1'($urandom);
         rx = 1'($urandom);
      end
      @(posedge clock);
      model_edge();
      @(negedge clock);
      rs = 0;
      check("locked", locked, m_st == 2);
      check("delay", dly, m_delay);
      check("bits", bits, m_bits);
      check("errors", errs, m_errs);
   endtask

   task automatic strobe();
      tick(1); tick(0); tick(0); tick(0);
   endtask

   initial begin
      lfsr = 9'($urandom_range(1, 511));
      m_reset();
      @(negedge clock); @(negedge clock);
      check("rst_locked", locked, 0);
      check("rst_bits", bits, 0);
      check("rst_errors", errs, 0);
      check("rst_delay", dly, 0);
      rst_n = 1;
      for (int k = 0; k < 20; k++) strobe();
      en = 1;
      tick(0);
      for (int k = 1; k <= 96; k++) begin
         strobe();
         if (k == 95) check("lock_at95", locked, 0);
      end
      check("lock_at96", locked, 1);
      check("lock_delay5", dly, 5);
      for (int k = 0; k < 50; k++) strobe();
      check("bits50", bits, 50);
      check("errs0", errs, 0);
      inv = 1;
      for (int k = 0; k < 3; k++) strobe();
      inv = 0;
      check("errs3", errs, 3);
      check("lock_kept", locked, 1);
      for (int k = 0; k < 147; k++) strobe();
      check("bits200", bits, 200);
      en = 0;
      tick(0);
      check("drop_unlock", locked, 0);
      check("drop_hold200", bits, 200);
      check("drop_hold_dly", dly, 5);
      en = 1;
      tick(0);
      check("reen_bits", bits, 0);
      check("reen_delay", dly, 0);
      for (int k = 0; k < 96; k++) strobe();
      check("relock", locked, 1);
      for (int k = 0; k < 10; k++) strobe();
      check("bits10", bits, 10);
      rs = 1;
      strobe();
      check("rs_bits", bits, 0);
      check("rs_unlock", locked, 0);
      check("rs_delay", dly, 0);
      for (int i = 0; i < 1000; i++) begin
         rs = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 99) == 0) en = ~en;
         if ($urandom_range(0, 199) == 0) dly_rx = $urandom_range(0, 12);
         inv = ($urandom_range(0, 29) == 0);
         strobe();
      end
      inv = 0; rs = 0;
      en = 0;
      tick(0);
      dly_rx = 511;
      seg = g_ref.size();
      en = 1;
      tick(0);
      for (int k = 1; k <= 8192; k++) begin
         strobe();
         if (k == 4080) check("d511_at255", dly, 255);
         if (k == 8191) begin
            check("d511_pre_lock", locked, 0);
            check("d511_pre_dly", dly, 511);
         end
      end
      check("d511_lock", locked, 1);
      check("d511_dly", dly, 511);
      en = 0;
      tick(0);
      rx_zero = 1;
      en = 1;
      tick(0);
      for (int k = 1; k <= 8192; k++) begin
         strobe();
         if (k == 8176) check("wrap_pre_dly", dly, 511);
      end
      check("wrap_dly0", dly, 0);
      check("wrap_nolock", locked, 0);
      rx_zero = 0;
      dly_rx = 5;
      en2 = 1;
      tick(0);
      for (int k = 0; k < 96; k++) strobe();
      check("sat_lock", locked2, 1);
      check("sat_dly", dly2, 5);
      inv2 = 1;
      for (int k = 1; k <= 20; k++) begin
         strobe();
         if (k == 14) begin
            check("sat_bits14", bits2, 14);
            check("sat_errs14", errs2, 14);
         end
      end
      check("sat_bits15", bits2, 15);
      check("sat_errs15", errs2, 15);
      check("sat_still_locked", locked2, 1);
      valid = 1;
      ref_b = 1'($urandom);
      #2 rst_n = 0;
      m_reset();
      #1;
      check("arst_bits2", bits2, 0);
      check("arst_errs2", errs2, 0);
      check("arst_locked2", locked2, 0);
      check("arst_dly2", dly2, 0);
      check("arst_bits", bits, 0);
      check("arst_locked", locked, 0);
      check("arst_dly", dly, 0);
      @(posedge clock);
      @(negedge clock);
      valid = 0;
      rst_n = 1;
      for (int k = 0; k < 30; k++) strobe();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/ber_checker.md
BER_CHECKER -- requirements
Module: ber_checker

Interface
REQ-001 Parameter NB_CNT, default 64: width of the bit and error accumulators.
REQ-002 Parameter NB_DLY, default 9: width of the alignment delay index; the delay line depth is DELAY_MAX = 2^NB_DLY = 512.
REQ-003 Parameter WINDOW, default 511: number of bits in each alignment-search window.
REQ-004 Parameter ERR_THR, default 0: maximum window errors that still declare lock.
REQ-005 clock  in  1  single clock for all logic.
REQ-006 i_reset_n  in  1  asynchronous, active-low reset.
REQ-007 i_enable  in  1  checker enable (register-file sw bit 1).
REQ-008 i_resync  in  1  single-cycle pulse that forces a new alignment search.
REQ-009 i_valid  in  1  symbol strobe; i_ref_bit and i_rx_bit are sampled only when it is high.
REQ-010 i_ref_bit  in  1  transmitted PRBS reference bit.
REQ-011 i_rx_bit  in  1  received slicer decision bit.
REQ-012 o_bits  out  NB_CNT  count of bits compared while locked.
REQ-013 o_errors  out  NB_CNT  count of mismatches while locked.
REQ-014 o_locked  out  1  high while in LOCK.
REQ-015 o_delay  out  NB_DLY  current or locked alignment delay.

Function
REQ-016 The delay line shall shift i_ref_bit in on every i_valid cycle, in all states; ref_d[0] is the current i_ref_bit and ref_d[k] is the reference bit from k strobes earlier.
REQ-017 On each i_valid, mismatch is defined as i_rx_bit XOR ref_d[o_delay].
REQ-018 The FSM shall have exactly three states: IDLE, SEARCH and LOCK.
REQ-019 IDLE to SEARCH occurs when i_enable=1; on that transition o_delay, the window counter, window errors, o_bits and o_errors all clear to 0.
REQ-020 In SEARCH, each i_valid shall increment the window count and add mismatch to the window error count (saturating).
REQ-021 On the WINDOW-th bit of a window, the FSM shall evaluate the total including that bit: if total is at most ERR_THR it goes to LOCK; otherwise o_delay increments, wrapping from DELAY_MAX-1 to 0, and the window counters clear.
REQ-022 In LOCK, each i_valid shall increment o_bits by 1 and add mismatch to o_errors.
REQ-023 o_bits and o_errors shall saturate at all-ones and never wrap.
REQ-024 Counter outputs shall be registered and reflect a strobe one clock after that i_valid.
REQ-025 i_enable=0 shall force IDLE from any state on the next edge; o_bits, o_errors and o_delay hold their values, and o_locked clears.
REQ-026 i_resync=1 with i_enable=1 shall force SEARCH with the same clearing as REQ-019; a same-cycle i_valid is not counted.
REQ-027 Priority on a simultaneous event shall be: i_enable=0, then i_resync, then i_valid; a sample coinciding with a higher-priority event is discarded.
REQ-028 LOCK shall persist regardless of error rate; only REQ-025 or REQ-026 leave it.
REQ-029 i_valid with no state change (IDLE) shall only shift the delay line.

Reset
REQ-030 Assertion of i_reset_n=0 shall immediately set state=IDLE, o_bits=0, o_errors=0, o_locked=0, o_delay=0, window counters=0 and the delay line to all zeros.
REQ-031 Reset deassertion mid-stream shall resume at IDLE; there is no retained search progress.

Structure
REQ-032 State encodings and the default values of NB_CNT, NB_DLY, WINDOW and ERR_THR shall live in shared package ber_pkg.
REQ-033 The delay line and its NB_DLY-bit select mux shall be the sub-module ref_delay_line, with ports clock, i_reset_n, i_valid, i_bit, i_sel and o_bit.
REQ-034 The FSM, counters and saturation logic shall stay in ber_checker.

Verification
Benches shall use WINDOW=16, ERR_THR=0, and a PRBS9 reference with one strobe every 4 clocks.
REQ-035 rx = ref delayed by 5 strobes, enable raised -> o_locked rises after the 96th strobe with o_delay=5; o_errors stays 0 and o_bits equals strobes counted since lock.
REQ-036 Locked, then rx inverted for exactly 3 strobes -> o_errors=3 one clock after the third, o_locked stays 1.
REQ-037 rx = ref delayed by 511 strobes -> search visits delays 0..510, locks at o_delay=511 with no wrap; a delay beyond 511 (rx constant 0) wraps o_delay 511 to 0 and never locks.
REQ-038 Enable dropped while locked with o_bits=200 -> o_locked=0 next edge and o_bits holds 200; enable re-raised -> counters clear and search restarts at delay 0.
REQ-039 i_resync coincident with i_valid while locked -> that strobe is not counted, o_bits=0 and state=SEARCH.
REQ-040 NB_CNT=4, locked, rx inverted for 20 strobes -> o_errors and o_bits saturate at 15; then i_reset_n pulsed mid-strobe -> all outputs 0 asynchronously.
